// File: rtl/btn_debouncer_pkg.sv
// Shared definitions for the push-button front end: channel count,
// default debounce length, button index constants and counter sizing.
package btn_debouncer_pkg;

    localparam int N_BTN               = 5;
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;  // 20 ms at 50 MHz

    // Button positions within btn[4:0]; the cpu indexes with the same values.
    typedef enum int {
        BTN_UP     = 0,
        BTN_DOWN   = 1,
        BTN_LEFT   = 2,
        BTN_RIGHT  = 3,
        BTN_CENTER = 4
    } btn_idx_e;

    // Counter width able to hold DEBOUNCE_CYCLES-1 (sized on cycles+1 for margin).
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/btn_debouncer_if.sv
// Button bundle between the board/cpu side (master) and the debouncer (slave).
interface btn_debouncer_if
    import btn_debouncer_pkg::*;
#(
    parameter int N = N_BTN
);
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_ack;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_event;

    modport master (
        output btn_raw,
        output btn_ack,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_event
    );

    modport slave (
        input  btn_raw,
        input  btn_ack,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_event
    );
endinterface

// File: rtl/btn_debouncer_channel.sv
// One button channel: 2-flop synchronizer, restartable debounce counter,
// debounced level, registered press/release strobes and sticky press flag.
module debounce_channel
    import btn_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    input  logic ack_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic event_o
);
    localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             event_q, event_d;
    logic             differs;
    logic             at_last;

    // Next-state: count while the synchronized input disagrees with the level;
    // the compare against CNT_LAST is what stops the counter, so it never wraps.
    always_comb begin
        differs   = s2_q ^ level_q;
        at_last   = (cnt_q == CNT_LAST);
        cnt_d     = '0;
        level_d   = level_q;
        if (differs) begin
            if (at_last) begin
                level_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d   = differs &  s2_q & at_last;
        release_d = differs & ~s2_q & at_last;
        // A new press beats a simultaneous ack.
        event_d   = (event_q & ~ack_i) | press_d;
    end

    // State registers; reset clears everything immediately, no clock needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            event_q   <= 1'b0;
        end else begin
            s1_q      <= raw_i;
            s2_q      <= s1_q;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            event_q   <= event_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign event_o   = event_q;

endmodule

// File: rtl/btn_debouncer.sv
// Board push-button conditioning: N_BTN independent debounce channels.
module btn_debouncer
    import btn_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic         clk,
    input  logic         rst,
    btn_debouncer_if.slave bus
);
    logic [N_BTN-1:0] level_w;
    logic [N_BTN-1:0] press_w;
    logic [N_BTN-1:0] release_w;
    logic [N_BTN-1:0] event_w;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .raw_i    (bus.btn_raw[gi]),
            .ack_i    (bus.btn_ack[gi]),
            .level_o  (level_w[gi]),
            .press_o  (press_w[gi]),
            .release_o(release_w[gi]),
            .event_o  (event_w[gi])
        );
    end

    assign bus.btn_level   = level_w;
    assign bus.btn_press   = press_w;
    assign bus.btn_release = release_w;
    assign bus.btn_event   = event_w;

endmodule

// File: tb/tb_btn_debouncer.sv
// Directed bench for btn_debouncer with DEBOUNCE_CYCLES=4, 20 ns clock.
module tb_btn_debouncer;
    import btn_debouncer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    btn_debouncer_if bus ();

    btn_debouncer #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #10 clk = ~clk;

    typedef struct {
        int         n;
        logic [4:0] raw, ack, lvl, prs, rel, evt;
    } vec_t;

    vec_t tbl[21];

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [4:0] l, input logic [4:0] p,
                             input logic [4:0] r, input logic [4:0] e);
        check({tag, ".level"},   bus.btn_level,   l);
        check({tag, ".press"},   bus.btn_press,   p);
        check({tag, ".release"}, bus.btn_release, r);
        check({tag, ".event"},   bus.btn_event,   e);
    endtask

    initial begin
        // n, raw, ack, level, press, release, event (values after the clock edge)
        tbl[0]  = '{5, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
        tbl[1]  = '{1, 5'b00001, 5'b00000, 5'b00001, 5'b00001, 5'b00000, 5'b00001};
        tbl[2]  = '{1, 5'b00001, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00001};
        tbl[3]  = '{1, 5'b00001, 5'b00001, 5'b00001, 5'b00000, 5'b00000, 5'b00000};
        tbl[4]  = '{1, 5'b00001, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00000};
        tbl[5]  = '{5, 5'b10011, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00000};
        tbl[6]  = '{1, 5'b10011, 5'b00000, 5'b10011, 5'b10010, 5'b00000, 5'b10010};
        tbl[7]  = '{1, 5'b10011, 5'b00000, 5'b10011, 5'b00000, 5'b00000, 5'b10010};
        tbl[8]  = '{5, 5'b00001, 5'b00000, 5'b10011, 5'b00000, 5'b00000, 5'b10010};
        tbl[9]  = '{1, 5'b00001, 5'b00000, 5'b00001, 5'b00000, 5'b10010, 5'b10010};
        tbl[10] = '{1, 5'b00001, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b10010};
        tbl[11] = '{5, 5'b01001, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b10010};
        tbl[12] = '{1, 5'b01001, 5'b00000, 5'b01001, 5'b01000, 5'b00000, 5'b11010};
        tbl[13] = '{1, 5'b01001, 5'b01000, 5'b01001, 5'b00000, 5'b00000, 5'b10010};
        tbl[14] = '{1, 5'b01001, 5'b01000, 5'b01001, 5'b00000, 5'b00000, 5'b10010};
        tbl[15] = '{5, 5'b00001, 5'b00000, 5'b01001, 5'b00000, 5'b00000, 5'b10010};
        tbl[16] = '{1, 5'b00001, 5'b00000, 5'b00001, 5'b00000, 5'b01000, 5'b10010};
        tbl[17] = '{1, 5'b00001, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b10010};
        tbl[18] = '{5, 5'b01001, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b10010};
        tbl[19] = '{1, 5'b01001, 5'b11010, 5'b01001, 5'b01000, 5'b00000, 5'b01000};
        tbl[20] = '{1, 5'b01001, 5'b00000, 5'b01001, 5'b00000, 5'b00000, 5'b01000};

        bus.btn_raw = 5'b00000;
        bus.btn_ack = 5'b00000;

        // Reset with all pads pressed: outputs stay clear, raw is ignored.
        #1;
        rst = 1'b1;
        bus.btn_raw = 5'h1F;
        #1;
        check_all("rst_async", 5'b0, 5'b0, 5'b0, 5'b0);
        for (int c = 0; c < 8; c++) begin
            tick();
            check_all($sformatf("rst_hold%0d", c), 5'b0, 5'b0, 5'b0, 5'b0);
        end
        bus.btn_raw = 5'b00000;
        #4;
        rst = 1'b0;

        // Clean press, ack, simultaneous press/release, ack race.
        for (int v = 0; v < 21; v++) begin
            for (int r = 0; r < tbl[v].n; r++) begin
                bus.btn_raw = tbl[v].raw;
                bus.btn_ack = tbl[v].ack;
                tick();
                check_all($sformatf("vec%0d.%0d", v, r), tbl[v].lvl, tbl[v].prs,
                          tbl[v].rel, tbl[v].evt);
            end
        end
        bus.btn_ack = 5'b00000;

        // Mid-cycle reset: outputs drop with no clock edge.
        #4;
        rst = 1'b1;
        bus.btn_raw = 5'b00000;
        #1;
        check_all("rst_mid", 5'b0, 5'b0, 5'b0, 5'b0);
        #2;
        rst = 1'b0;

        // Bounce on channel 2: 3-cycle pulses never reach the level.
        for (int c = 0; c < 30; c++) begin
            bus.btn_raw = ((c / 3) % 2 == 0) ? 5'b00100 : 5'b00000;
            tick();
            check({$sformatf("bounce%0d", c), ".level"}, bus.btn_level, 5'b0);
            check({$sformatf("bounce%0d", c), ".strobes"}, bus.btn_press | bus.btn_release, 5'b0);
        end
        bus.btn_raw = 5'b00100;
        for (int c = 1; c <= 7; c++) begin
            tick();
            check($sformatf("settle%0d.press", c), bus.btn_press, (c == 6) ? 5'b00100 : 5'b00000);
            check($sformatf("settle%0d.level", c), bus.btn_level, (c >= 6) ? 5'b00100 : 5'b00000);
        end
        bus.btn_raw = 5'b00000;
        for (int c = 0; c < 8; c++) tick();

        // Reset mid-count: progress is lost, press needs a full fresh count.
        bus.btn_raw = 5'b00001;
        for (int c = 0; c < 4; c++) tick();
        #4;
        rst = 1'b1;
        #1;
        check_all("rst_count", 5'b0, 5'b0, 5'b0, 5'b0);
        #2;
        rst = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            check($sformatf("recount%0d.press", c), bus.btn_press, (c == 6) ? 5'b00001 : 5'b00000);
            check($sformatf("recount%0d.level", c), bus.btn_level, (c >= 6) ? 5'b00001 : 5'b00000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
